// File: rtl/ir_fetch_ctrl_if.sv
// rtl/ir_fetch_ctrl_if.sv - handshake and strobe bundle between control FSM, IR path and fetch sequencer
interface ir_fetch_ctrl_if #(
    parameter int COUNT_W = 16
);
    // Inputs to the sequencer from the control FSM, memory and decoder side
    logic               run;
    logic               mem_ready;
    logic               exec_done;
    logic [3:0]         ir_opcode;

    // Strobes and status driven by the sequencer
    logic               pc_out_en;
    logic               mar_write;
    logic               mem_read;
    logic               ir_write;
    logic               ir_read;
    logic               pc_inc;
    logic               exec_start;
    logic               halted;
    logic               fault;
    logic [COUNT_W-1:0] instr_count;
    logic [2:0]         state_dbg;

    // Sequencer side: consumes the handshake inputs, drives the datapath strobes
    modport master (
        input  run,
        input  mem_ready,
        input  exec_done,
        input  ir_opcode,
        output pc_out_en,
        output mar_write,
        output mem_read,
        output ir_write,
        output ir_read,
        output pc_inc,
        output exec_start,
        output halted,
        output fault,
        output instr_count,
        output state_dbg
    );

    // Environment side: control FSM, memory and datapath
    modport slave (
        output run,
        output mem_ready,
        output exec_done,
        output ir_opcode,
        input  pc_out_en,
        input  mar_write,
        input  mem_read,
        input  ir_write,
        input  ir_read,
        input  pc_inc,
        input  exec_start,
        input  halted,
        input  fault,
        input  instr_count,
        input  state_dbg
    );
endinterface

// File: rtl/ir_fetch_ctrl.sv
// rtl/ir_fetch_ctrl.sv - fetch/decode sequencer driving the PC, MAR, memory and IR strobes
module ir_fetch_ctrl #(
    parameter logic [3:0] HALT_OPCODE  = 4'hF,
    parameter int         WAIT_TIMEOUT = 15,
    parameter int         COUNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    ir_fetch_ctrl_if.master   bus
);

    localparam int CW = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(WAIT_TIMEOUT);

    // Encoding is visible on state_dbg, so the values are fixed
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WAIT   = 3'd2,
        S_LOAD   = 3'd3,
        S_DECODE = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      wait_q, wait_d;
    logic [COUNT_W-1:0] count_q, count_d;

    // Counter value including the current WAIT cycle; equals the number of
    // WAIT cycles spent so far once this cycle ends
    logic [CW-1:0]      wait_inc;
    assign wait_inc = wait_q + 1'b1;

    // State, wait counter and instruction counter registers; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Next-state logic; run is only consulted in IDLE and on EXEC exit
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.run) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                wait_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_inc;
                // A ready memory takes priority over a timeout in the same cycle
                if (bus.mem_ready) begin
                    state_d = S_LOAD;
                end else if (wait_inc == WAIT_LIMIT) begin
                    state_d = S_FAULT;
                end
            end
            S_LOAD: begin
                count_d = count_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (bus.ir_opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (bus.exec_done) begin
                    state_d = bus.run ? S_ADDR : S_IDLE;
                end
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore strobe decode; exec_start additionally qualifies DECODE with the opcode
    always_comb begin
        bus.pc_out_en  = 1'b0;
        bus.mar_write  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.ir_read    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.exec_start = 1'b0;
        bus.halted     = 1'b0;
        bus.fault      = 1'b0;
        case (state_q)
            S_ADDR: begin
                bus.pc_out_en = 1'b1;
                bus.mar_write = 1'b1;
            end
            S_WAIT: begin
                bus.mem_read = 1'b1;
            end
            S_LOAD: begin
                bus.mem_read = 1'b1;
                bus.ir_write = 1'b1;
                bus.pc_inc   = 1'b1;
            end
            S_DECODE: begin
                bus.ir_read    = 1'b1;
                bus.exec_start = (bus.ir_opcode != HALT_OPCODE);
            end
            S_EXEC: begin
                bus.ir_read = 1'b1;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            S_FAULT: begin
                bus.fault = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.instr_count = count_q;
    assign bus.state_dbg   = state_q;

endmodule
